// File: rtl/sha256_compress.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sha256_compress : 64-round SHA-256 compression, one round per clock  |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module sha256_compress #(
    parameter int W_LENGTH   = 64,
    parameter int WORD_WIDTH = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [W_LENGTH*WORD_WIDTH-1:0] w_vector,
    input  logic [8*WORD_WIDTH-1:0]        prev_hash,
    output logic                           busy,
    output logic                           hash_complete,
    output logic [8*WORD_WIDTH-1:0]        hash_out
);

    localparam int CNT_W = $clog2(W_LENGTH);
    localparam int SCH_W = W_LENGTH * WORD_WIDTH;

    localparam logic [31:0] C_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_round;
    logic [SCH_W-1:0]        r_sched;
    logic [8*WORD_WIDTH-1:0] r_prev;
    logic [31:0]             r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;

    logic [31:0] w_wt, w_s0, w_s1, w_ch, w_maj, w_t1, w_t2;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Schedule register shifts left each round, so W[t] is always the top word.
    assign w_wt  = r_sched[SCH_W-1 -: WORD_WIDTH];
    assign w_s1  = rotr(r_e, 6) ^ rotr(r_e, 11) ^ rotr(r_e, 25);
    assign w_ch  = (r_e & r_f) ^ (~r_e & r_g);
    assign w_t1  = r_h + w_s1 + w_ch + C_K[r_round] + w_wt;
    assign w_s0  = rotr(r_a, 2) ^ rotr(r_a, 13) ^ rotr(r_a, 22);
    assign w_maj = (r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c);
    assign w_t2  = w_s0 + w_maj;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_round       <= '0;
            r_sched       <= '0;
            r_prev        <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= '0;
            r_d           <= '0;
            r_e           <= '0;
            r_f           <= '0;
            r_g           <= '0;
            r_h           <= '0;
            busy          <= 1'b0;
            hash_complete <= 1'b0;
            hash_out      <= '0;
        end else begin
            hash_complete <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_sched <= w_vector;
                        r_prev  <= prev_hash;
                        r_a     <= prev_hash[255:224];
                        r_b     <= prev_hash[223:192];
                        r_c     <= prev_hash[191:160];
                        r_d     <= prev_hash[159:128];
                        r_e     <= prev_hash[127:96];
                        r_f     <= prev_hash[95:64];
                        r_g     <= prev_hash[63:32];
                        r_h     <= prev_hash[31:0];
                        r_round <= '0;
                        busy    <= 1'b1;
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_h     <= r_g;
                    r_g     <= r_f;
                    r_f     <= r_e;
                    r_e     <= r_d + w_t1;
                    r_d     <= r_c;
                    r_c     <= r_b;
                    r_b     <= r_a;
                    r_a     <= w_t1 + w_t2;
                    r_sched <= r_sched << WORD_WIDTH;
                    r_round <= r_round + 1'b1;
                    if (r_round == CNT_W'(W_LENGTH - 1)) begin
                        r_state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    hash_out <= {r_prev[255:224] + r_a, r_prev[223:192] + r_b,
                                 r_prev[191:160] + r_c, r_prev[159:128] + r_d,
                                 r_prev[127:96]  + r_e, r_prev[95:64]   + r_f,
                                 r_prev[63:32]   + r_g, r_prev[31:0]    + r_h};
                    hash_complete <= 1'b1;
                    busy          <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_compress.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sha256_compress : vector, random and corner-case checks           |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_sha256_compress;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic           clock = 1'b0;
    logic           reset;
    logic           enable;
    logic [2047:0]  w_vector;
    logic [255:0]   prev_hash;
    logic           busy;
    logic           hash_complete;
    logic [255:0]   hash_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int           pulse_cyc  [$];
    logic [255:0] pulse_hash [$];
    logic         pulse_busy [$];

    sha256_compress #(.W_LENGTH(64), .WORD_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .enable(enable), .w_vector(w_vector),
        .prev_hash(prev_hash), .busy(busy), .hash_complete(hash_complete), .hash_out(hash_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (hash_complete === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pulse_hash.push_back(hash_out);
            pulse_busy.push_back(busy);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [2047:0] expand(input logic [511:0] blk);
        logic [31:0]   w [64];
        logic [2047:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 64; i++) r[2047 - 32*i -: 32] = w[i];
        return r;
    endfunction

    function automatic logic [255:0] model(input logic [2047:0] wv, input logic [255:0] ph);
        logic [31:0]  v [8];
        logic [31:0]  hh [8];
        logic [31:0]  t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            hh[i] = ph[255 - 32*i -: 32];
            v[i]  = hh[i];
        end
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + wv[2047 - 32*t -: 32];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hh[i] + v[i];
        return r;
    endfunction

    // ---------------- check helpers ----------------
    task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkint(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start(input logic [2047:0] wv, input logic [255:0] ph, output int e);
        @(negedge clock);
        enable    = 1'b1;
        w_vector  = wv;
        prev_hash = ph;
        @(posedge clock);
        #1;
        e      = cyc;
        enable = 1'b0;
    endtask

    task automatic wait_pulse(input int n_before, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            #1;
            if (pulse_cyc.size() > n_before) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chkint({name, "_timeout"}, 0, 1);
    endtask

    function automatic logic [2047:0] rand_w();
        logic [2047:0] r;
        for (int k = 0; k < 64; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] rand_h();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    typedef struct {
        logic [511:0] blk;
        logic [255:0] prev;
        logic [255:0] exp;
    } vec_t;

    vec_t         tab [2];
    logic [511:0] blk_abc, blk_empty, blk_two1, blk_two2;
    logic [2047:0] wv;
    logic [255:0]  ph, h1;
    int e, n0;
    bit ok;

    initial begin
        blk_abc   = {32'h61626380, {14{32'h0}}, 32'h00000018};
        blk_empty = {32'h80000000, {15{32'h0}}};
        blk_two1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk_two2  = {{15{32'h0}}, 32'h000001c0};
        tab[0] = '{blk: blk_abc,   prev: IV, exp: D_ABC};
        tab[1] = '{blk: blk_empty, prev: IV, exp: D_EMPTY};

        reset     = 1'b0;
        enable    = 1'b0;
        w_vector  = '0;
        prev_hash = '0;
        repeat (3) @(negedge clock);
        chkint("reset_busy", int'(busy), 0);
        chkint("reset_complete", int'(hash_complete), 0);
        chk256("reset_hash", hash_out, '0);
        reset = 1'b1;

        // known-answer vectors
        for (int i = 0; i < 2; i++) begin
            n0 = pulse_cyc.size();
            start(expand(tab[i].blk), tab[i].prev, e);
            chkint("busy_after_start", int'(busy), 1);
            wait_pulse(n0, "vec", ok);
            if (ok) begin
                chkint("vec_latency", pulse_cyc[n0] - e, 65);
                chk256("vec_digest", pulse_hash[n0], tab[i].exp);
                chkint("vec_busy_at_done", int'(pulse_busy[n0]), 0);
            end
        end
        repeat (5) @(negedge clock);
        chk256("hash_hold", hash_out, D_EMPTY);
        chkint("single_pulse", int'(hash_complete), 0);

        // random schedules and chaining values against the model
        for (int i = 0; i < 4; i++) begin
            wv = rand_w();
            ph = rand_h();
            n0 = pulse_cyc.size();
            start(wv, ph, e);
            wait_pulse(n0, "rand", ok);
            if (ok) begin
                chkint("rand_latency", pulse_cyc[n0] - e, 65);
                chk256("rand_digest", pulse_hash[n0], model(wv, ph));
            end
        end

        // busy lockout: inputs scrambled and enable held during rounds
        n0 = pulse_cyc.size();
        start(expand(blk_abc), IV, e);
        repeat (10) @(negedge clock);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            #1;
            if (pulse_cyc.size() > n0) begin
                enable = 1'b0;
                break;
            end
            enable    = 1'b1;
            w_vector  = rand_w();
            prev_hash = rand_h();
        end
        enable = 1'b0;
        repeat (80) @(negedge clock);
        chkint("lock_pulses", pulse_cyc.size(), n0 + 1);
        chk256("lock_hash", hash_out, D_ABC);

        // asynchronous reset mid-block
        n0 = pulse_cyc.size();
        start(expand(blk_abc), IV, e);
        repeat (30) @(negedge clock);
        reset = 1'b0;
        #1;
        chkint("rst_busy", int'(busy), 0);
        chkint("rst_complete", int'(hash_complete), 0);
        chk256("rst_hash", hash_out, '0);
        @(negedge clock);
        reset = 1'b1;
        repeat (50) @(negedge clock);
        chkint("rst_no_pulse", pulse_cyc.size(), n0);
        start(expand(blk_abc), IV, e);
        wait_pulse(n0, "rst_rerun", ok);
        if (ok) chk256("rst_rerun_digest", pulse_hash[n0], D_ABC);

        // back-to-back: enable during FINAL ignored, next cycle accepted
        n0 = pulse_cyc.size();
        start(expand(blk_abc), IV, e);
        while (cyc < e + 64) @(negedge clock);
        enable    = 1'b1;
        w_vector  = expand(blk_empty);
        prev_hash = IV;
        @(posedge clock);
        @(posedge clock);
        #1;
        enable = 1'b0;
        wait_pulse(n0 + 1, "b2b", ok);
        chkint("b2b_pulses", pulse_cyc.size(), n0 + 2);
        if (pulse_cyc.size() >= n0 + 2) begin
            chkint("b2b_first_latency", pulse_cyc[n0] - e, 65);
            chkint("b2b_spacing", pulse_cyc[n0+1] - pulse_cyc[n0], 66);
            chk256("b2b_first", pulse_hash[n0], D_ABC);
            chk256("b2b_second", pulse_hash[n0+1], D_EMPTY);
        end

        // two-block chaining
        n0 = pulse_cyc.size();
        start(expand(blk_two1), IV, e);
        wait_pulse(n0, "chain1", ok);
        h1 = ok ? pulse_hash[n0] : '0;
        chk256("chain_block1", h1, model(expand(blk_two1), IV));
        start(expand(blk_two2), h1, e);
        wait_pulse(n0 + 1, "chain2", ok);
        if (ok) chk256("chain_final", pulse_hash[n0+1], D_TWO);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
